// File: rtl/bcd_pkg.sv
// Shared constants, FSM state type and helpers for the multi-channel BCD converter.
package bcd_pkg;

  localparam int unsigned BCD_W     = 4;
  localparam logic [3:0]  BCD_BLANK = 4'hF;
  localparam logic [3:0]  BCD_NINE  = 4'h9;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    STORE,
    DONE
  } state_e;

  // 10**n, used to derive the per-channel overflow threshold at elaboration
  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// Combinational add-3 correction of every BCD digit that is 5 or more (one double-dabble step
// before the shift).
module bcd_dabble_step
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 3
) (
  input  logic [DIGITS*BCD_W-1:0] bcd_in,
  output logic [DIGITS*BCD_W-1:0] bcd_adj_c
);

  always_comb begin
    bcd_adj_c = bcd_in;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd_in[i*BCD_W +: BCD_W] >= 4'd5) begin
        bcd_adj_c[i*BCD_W +: BCD_W] = bcd_in[i*BCD_W +: BCD_W] + 4'd3;
      end
    end
  end

endmodule

// File: rtl/bcd_multi_converter.sv
// Sequential multi-channel binary-to-BCD converter sharing one double-dabble datapath.
// Optional leading-zero blanking when BCD_LZ_BLANK_EN is defined.
module bcd_multi_converter
  import bcd_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned IN_W   = 10,
  parameter int unsigned DIGITS = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NUM_CH*IN_W-1:0]         in_data,
  input  logic [NUM_CH-1:0]              ch_en,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NUM_CH*DIGITS*BCD_W-1:0] out_bcd,
  output logic [NUM_CH-1:0]              out_ovf
);

  localparam int unsigned SLOT_W = DIGITS * BCD_W;
  localparam int unsigned SR_W   = IN_W + SLOT_W;
  localparam int unsigned BIT_W  = $clog2(IN_W + 1);
  localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [63:0] OVF_THR = pow10(DIGITS);

  state_e                     state_q, state_d;
  logic [CH_W-1:0]            ch_q, ch_d;
  logic [BIT_W-1:0]           bit_q, bit_d;
  logic [SR_W-1:0]            sr_q, sr_d;
  logic [NUM_CH*IN_W-1:0]     data_q, data_d;
  logic [NUM_CH-1:0]          en_q, en_d;
  logic                       in_ready_q, in_ready_d;
  logic                       out_valid_q, out_valid_d;
  logic [NUM_CH*SLOT_W-1:0]   out_bcd_q, out_bcd_d;
  logic [NUM_CH-1:0]          out_ovf_q, out_ovf_d;

  logic [IN_W-1:0]            cur_val_c;
  logic [SLOT_W-1:0]          cur_bcd_c;
  logic [SLOT_W-1:0]          adj_c;
  logic [SLOT_W-1:0]          slot_c;

  assign cur_val_c = data_q[ch_q*IN_W +: IN_W];
  assign cur_bcd_c = sr_q[SR_W-1 -: SLOT_W];

  bcd_dabble_step #(
    .DIGITS (DIGITS)
  ) u_step (
    .bcd_in    (cur_bcd_c),
    .bcd_adj_c (adj_c)
  );

  // Final slot contents: blank for disabled channels, saturate on overflow
  always_comb begin
`ifdef BCD_LZ_BLANK_EN
    logic lead;
    lead = 1'b1;
`endif
    slot_c = cur_bcd_c;
    if (!en_q[ch_q]) begin
      slot_c = {DIGITS{BCD_BLANK}};
    end else if (out_ovf_q[ch_q]) begin
      slot_c = {DIGITS{BCD_NINE}};
    end
`ifdef BCD_LZ_BLANK_EN
    else begin
      // Units digit is never blanked so a zero value still shows "0"
      for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
        if (lead && (cur_bcd_c[i*BCD_W +: BCD_W] == 4'd0)) begin
          slot_c[i*BCD_W +: BCD_W] = BCD_BLANK;
        end else begin
          lead = 1'b0;
        end
      end
    end
`endif
  end

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    bit_d       = bit_q;
    sr_d        = sr_q;
    data_d      = data_q;
    en_d        = en_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_bcd_d   = out_bcd_q;
    out_ovf_d   = out_ovf_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d     = in_data;
          en_d       = ch_en;
          ch_d       = '0;
          in_ready_d = 1'b0;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        sr_d            = {SLOT_W'(0), cur_val_c};
        bit_d           = '0;
        out_ovf_d[ch_q] = (64'(cur_val_c) >= OVF_THR);
        state_d         = SHIFT;
      end
      SHIFT: begin
        sr_d  = {adj_c, sr_q[IN_W-1:0]} << 1;
        bit_d = bit_q + BIT_W'(1);
        if (bit_q == BIT_W'(IN_W - 1)) begin
          state_d = STORE;
        end
      end
      STORE: begin
        out_bcd_d[ch_q*SLOT_W +: SLOT_W] = slot_c;
        if (!en_q[ch_q]) begin
          out_ovf_d[ch_q] = 1'b0;
        end
        if (ch_q == CH_W'(NUM_CH - 1)) begin
          ch_d        = '0;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          ch_d    = ch_q + CH_W'(1);
          state_d = LOAD;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ch_q        <= '0;
      bit_q       <= '0;
      sr_q        <= '0;
      data_q      <= '0;
      en_q        <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_bcd_q   <= '0;
      out_ovf_q   <= '0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      bit_q       <= bit_d;
      sr_q        <= sr_d;
      data_q      <= data_d;
      en_q        <= en_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_bcd_q   <= out_bcd_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_bcd   = out_bcd_q;
  assign out_ovf   = out_ovf_q;

endmodule
